icache_refill_assembler: RTL and testbench
==========================================

Name: icache_refill_assembler

Overview:
- Downstream of the AXI shim read port, upstream of the L1I$ return interface.
- Collects 64-bit AXI R beats into a full I$ line, or a single word for non-cacheable fetches.
- Keeps a small FIFO of outstanding refill requests (tid, nc) so more than one AXI read can be in flight.
- Presents a one-cycle registered return pulse with a protocol checker.

Parameters:
- LineWidth, 128, I$ line width in bits; multiple of 64, at least 64.
- IdWidth, 4, AXI ID / tid width.
- NumPending, 2, depth of the outstanding-request FIFO; power of 2, at least 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_valid_i  in  1  refill request issued to AXI (asserted when the AR is granted)
- req_ready_o  out  1  request FIFO not full
- req_tid_i  in  IdWidth  request ID
- req_nc_i  in  1  non-cacheable, single beat
- beat_valid_i  in  1  R beat valid
- beat_ready_o  out  1  beat accepted (high when the FIFO is non-empty)
- beat_data_i  in  64  R data
- beat_last_i  in  1  R last
- beat_id_i  in  IdWidth  R id
- beat_resp_i  in  2  R resp
- line_valid_o  out  1  line return pulse
- line_data_o  out  LineWidth  assembled line
- line_tid_o  out  IdWidth  tid of the returned line
- line_nc_o  out  1  returned request was nc
- line_err_o  out  1  error seen on any beat of the line
- proto_err_o  out  1  sticky protocol violation
- busy_o  out  1  FIFO non-empty or beat count non-zero

Behaviour:
- Interface: reset rst_ni, asynchronous, active-low; clock clk_i.
- Reset values: all outputs 0 except req_ready_o=1. FIFO empty, beat_cnt=0, shift buffer 0, error accumulator 0.
- Request push: when req_valid_i && req_ready_o. req_ready_o = !full; no bypass when full, even if a pop happens that cycle.
- Push and pop in the same cycle: allowed when not full; occupancy is unchanged.
- Beat acceptance: when beat_valid_i && beat_ready_o. With the FIFO empty, beat_ready_o=0 and the beat is not consumed.
- Accepted beat, FIFO head cacheable: data is written to word slot beat_cnt; beat_cnt increments and wraps to 0 on last.
- Accepted beat, FIFO head nc: data is written to slot 0; all other slots are zeroed.
- Error accumulation: err_acc |= resp[1] on every accepted beat; cleared at line completion.
- Line completion: accepted beat with beat_last_i=1. On the next clock:
  - line_valid_o=1 for exactly one cycle;
  - line_data_o, line_tid_o, line_nc_o reflect the head entry and the assembled data;
  - the FIFO head pops in the completion cycle.
- Latency: one cycle from the last beat handshake to line_valid_o.
- Output holding: line_data_o, line_tid_o and line_nc_o hold their values until the next completion.
- Back-to-back bursts: a beat of the next line may be accepted in the cycle the previous line_valid_o is high.
- Protocol checks; each sets proto_err_o sticky until reset:
  - beat_id_i differs from the head tid;
  - cacheable burst with beat_last_i at beat_cnt != LineWidth/64-1;
  - nc burst with beat_cnt != 0 at last;
  - beat_cnt reaching LineWidth/64-1 without last.
- Assembly continues despite a protocol error. A wrong-count last still completes the line and pops the head. Missing-last overflow wraps beat_cnt to 0.
- LineWidth=64: cacheable and nc behave identically; every beat must be last.
- Reset mid-burst: the FIFO, counter and partial data are discarded; no line_valid_o is emitted.

Optional Feature:
- Macro: ICACHE_REFILL_ERR_EN.
- Defined: err_acc is implemented, line_err_o reflects SLVERR/DECERR of the line, and proto_err_o also sets on beat_resp_i == EXOKAY (2'b01), which is illegal for fetches.
- Undefined: line_err_o tied 0, no error accumulator flop, resp ignored.

Decomposition:
- wt_cache_pkg holds:
  - the localparam for the number of beats per line (ICACHE_LINE_WIDTH/64);
  - a packed refill_pending_t struct {tid, nc};
  - AXI resp encodings (RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR).
- One sub-module: the existing generic fifo_v3 instance for the pending FIFO (DATA_WIDTH=$bits(refill_pending_t), DEPTH=NumPending).
- The assembly datapath and checker stay in the top module.

Test Plan:
- Cacheable refill: push tid=0 nc=0; beats 0xA,0xB (last) id=0 -> one cycle later line_valid_o=1, line_data_o={0xB,0xA}, line_tid_o=0, proto_err_o=0.
- Non-cacheable fetch: push tid=1 nc=1; one beat 0x1234 last id=1 -> line_data_o={0,0x1234}, line_nc_o=1.
- Two outstanding: push tid=2 then tid=3, third push blocked (req_ready_o=0) -> two back-to-back lines return tid 2 then 3 in order, busy_o falls after the second.
- Bad burst: cacheable with last on beat 0 -> line_valid_o pulses, proto_err_o=1 and remains 1; beat with id=5 while head tid=4 -> proto_err_o=1.
- Errors (ICACHE_REFILL_ERR_EN): beat 0 resp=2'b10, beat 1 OKAY -> line_err_o=1; following clean line -> line_err_o=0. Without the macro -> line_err_o=0.
- Reset: assert rst_ni low after beat 0 of a burst -> no line_valid_o, req_ready_o=1, busy_o=0; a fresh refill then completes correctly.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared I$ refill types: beats per line, pending-request entry and AXI response encodings.
package wt_cache_pkg;

  localparam int unsigned ICACHE_LINE_WIDTH = 128;
  localparam int unsigned ICACHE_BEATS      = ICACHE_LINE_WIDTH / 64;
  localparam int unsigned ICACHE_ID_WIDTH   = 4;

  typedef struct packed {
    logic [ICACHE_ID_WIDTH-1:0] tid;
    logic                       nc;
  } refill_pending_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO with registered storage; head is visible on data_o while non-empty.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AddrW-1:0] LastAddr = AddrW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [AddrW:0]        cnt_q;
  logic                  push_en, pop_en;

  assign full_o  = (cnt_q == (AddrW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
    return (p == LastAddr) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_en && !pop_en)      cnt_q <= cnt_q + 1'b1;
      else if (pop_en && !push_en) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/icache_refill_assembler.sv
// Assembles AXI R beats into I$ lines (or single nc words) for outstanding refills.
// Optional ICACHE_REFILL_ERR_EN: per-line SLVERR/DECERR reporting and EXOKAY protocol check.
module icache_refill_assembler
  import wt_cache_pkg::*;
#(
  parameter int unsigned LineWidth  = ICACHE_LINE_WIDTH,
  parameter int unsigned IdWidth    = ICACHE_ID_WIDTH,
  parameter int unsigned NumPending = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IdWidth-1:0]   req_tid_i,
  input  logic                 req_nc_i,
  input  logic                 beat_valid_i,
  output logic                 beat_ready_o,
  input  logic [63:0]          beat_data_i,
  input  logic                 beat_last_i,
  input  logic [IdWidth-1:0]   beat_id_i,
  input  logic [1:0]           beat_resp_i,
  output logic                 line_valid_o,
  output logic [LineWidth-1:0] line_data_o,
  output logic [IdWidth-1:0]   line_tid_o,
  output logic                 line_nc_o,
  output logic                 line_err_o,
  output logic                 proto_err_o,
  output logic                 busy_o
);

  localparam int unsigned Beats = LineWidth / 64;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  refill_pending_t push_entry, head;
  logic fifo_full, fifo_empty;
  logic req_fire, beat_fire, line_done;

  logic [Beats-1:0][63:0] buf_q, buf_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   proto_hit;

  logic                   line_valid_q, line_nc_q, proto_q;
  logic [LineWidth-1:0]   line_data_q;
  logic [IdWidth-1:0]     line_tid_q;

  assign req_ready_o  = !fifo_full;
  assign beat_ready_o = !fifo_empty;
  assign req_fire     = req_valid_i && !fifo_full;
  assign beat_fire    = beat_valid_i && !fifo_empty;
  assign line_done    = beat_fire && beat_last_i;

  assign push_entry.tid = ICACHE_ID_WIDTH'(req_tid_i);
  assign push_entry.nc  = req_nc_i;

  fifo_v3 #(
    .DATA_WIDTH ($bits(refill_pending_t)),
    .DEPTH      (NumPending)
  ) i_pending_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (push_entry),
    .push_i  (req_fire),
    .data_o  (head),
    .pop_i   (line_done)
  );

  // Protocol violations are flagged but never stall assembly.
  always_comb begin
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    proto_hit = 1'b0;
    if (beat_fire) begin
      if (head.nc) begin
        buf_d    = '0;
        buf_d[0] = beat_data_i;
      end else begin
        buf_d[cnt_q] = beat_data_i;
      end
      if (beat_last_i || cnt_q == LastCnt) cnt_d = '0;
      else                                 cnt_d = cnt_q + 1'b1;
      if (beat_id_i != IdWidth'(head.tid))                  proto_hit = 1'b1;
      if (beat_last_i && !head.nc && cnt_q != LastCnt)      proto_hit = 1'b1;
      if (beat_last_i && head.nc && cnt_q != '0)            proto_hit = 1'b1;
      if (!beat_last_i && cnt_q == LastCnt)                 proto_hit = 1'b1;
`ifdef ICACHE_REFILL_ERR_EN
      if (beat_resp_i == RESP_EXOKAY)                       proto_hit = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q        <= '0;
      cnt_q        <= '0;
      line_valid_q <= 1'b0;
      line_data_q  <= '0;
      line_tid_q   <= '0;
      line_nc_q    <= 1'b0;
      proto_q      <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      line_valid_q <= line_done;
      if (proto_hit) proto_q <= 1'b1;
      if (line_done) begin
        line_data_q <= buf_d;
        line_tid_q  <= IdWidth'(head.tid);
        line_nc_q   <= head.nc;
      end
    end
  end

`ifdef ICACHE_REFILL_ERR_EN
  logic err_acc_q, err_acc_d, line_err_q;

  assign err_acc_d = err_acc_q | (beat_fire & beat_resp_i[1]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_acc_q  <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      err_acc_q <= line_done ? 1'b0 : err_acc_d;
      if (line_done) line_err_q <= err_acc_d;
    end
  end

  assign line_err_o = line_err_q;
`else
  logic unused_resp;
  assign unused_resp = ^beat_resp_i;
  assign line_err_o  = 1'b0;
`endif

  assign line_valid_o = line_valid_q;
  assign line_data_o  = line_data_q;
  assign line_tid_o   = line_tid_q;
  assign line_nc_o    = line_nc_q;
  assign proto_err_o  = proto_q;
  assign busy_o       = !fifo_empty || (cnt_q != '0);

endmodule

// File: tb/tb_icache_refill_assembler.sv
// Scoreboard bench for icache_refill_assembler: expected lines queued at the last beat, checked on line_valid_o.
module tb_icache_refill_assembler;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic [3:0]   req_tid_i = '0;
  logic         req_nc_i = 1'b0;
  logic         beat_valid_i = 1'b0;
  logic         beat_ready_o;
  logic [63:0]  beat_data_i = '0;
  logic         beat_last_i = 1'b0;
  logic [3:0]   beat_id_i = '0;
  logic [1:0]   beat_resp_i = '0;
  logic         line_valid_o;
  logic [127:0] line_data_o;
  logic [3:0]   line_tid_o;
  logic         line_nc_o;
  logic         line_err_o;
  logic         proto_err_o;
  logic         busy_o;

`ifdef ICACHE_REFILL_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  typedef struct {
    logic [127:0] data;
    logic [3:0]   tid;
    logic         nc;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  icache_refill_assembler #(
    .LineWidth  (128),
    .IdWidth    (4),
    .NumPending (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_tid_i    (req_tid_i),
    .req_nc_i     (req_nc_i),
    .beat_valid_i (beat_valid_i),
    .beat_ready_o (beat_ready_o),
    .beat_data_i  (beat_data_i),
    .beat_last_i  (beat_last_i),
    .beat_id_i    (beat_id_i),
    .beat_resp_i  (beat_resp_i),
    .line_valid_o (line_valid_o),
    .line_data_o  (line_data_o),
    .line_tid_o   (line_tid_o),
    .line_nc_o    (line_nc_o),
    .line_err_o   (line_err_o),
    .proto_err_o  (proto_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  exp_t e_mon;
  always @(negedge clk_i) begin
    if (rst_ni && line_valid_o) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_line", {127'd0, line_valid_o}, 128'd0);
      end else begin
        e_mon = sb.pop_front();
        check_eq("line_data", line_data_o, e_mon.data);
        check_eq("line_tid", {124'd0, line_tid_o}, {124'd0, e_mon.tid});
        check_eq("line_nc", {127'd0, line_nc_o}, {127'd0, e_mon.nc});
        check_eq("line_err", {127'd0, line_err_o}, {127'd0, e_mon.err});
      end
    end
  end

  task automatic push_req(input logic [3:0] tid, input logic nc);
    req_valid_i = 1'b1;
    req_tid_i   = tid;
    req_nc_i    = nc;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic [3:0] id, input logic last, input logic [1:0] resp);
    beat_valid_i = 1'b1;
    beat_data_i  = d;
    beat_id_i    = id;
    beat_last_i  = last;
    beat_resp_i  = resp;
    @(posedge clk_i);
    #1 beat_valid_i = 1'b0;
    beat_last_i = 1'b0;
  endtask

  task automatic expect_line(input logic [127:0] d, input logic [3:0] tid, input logic nc, input logic err);
    exp_t e;
    e.data = d;
    e.tid  = tid;
    e.nc   = nc;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk_i);
    @(posedge clk_i);
    #1 check_eq(tag, 128'(sb.size()), 128'd0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_req_ready", {127'd0, req_ready_o}, 128'd1);
    check_eq("rst_beat_ready", {127'd0, beat_ready_o}, 128'd0);
    check_eq("rst_busy", {127'd0, busy_o}, 128'd0);
    check_eq("rst_line_valid", {127'd0, line_valid_o}, 128'd0);
    check_eq("rst_line_data", line_data_o, 128'd0);
    check_eq("rst_proto", {127'd0, proto_err_o}, 128'd0);
    check_eq("rst_line_err", {127'd0, line_err_o}, 128'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // cacheable two-beat line
    push_req(4'd0, 1'b0);
    beat(64'hA, 4'd0, 1'b0, 2'b00);
    expect_line({64'hB, 64'hA}, 4'd0, 1'b0, 1'b0);
    beat(64'hB, 4'd0, 1'b1, 2'b00);
    @(negedge clk_i);
    check_eq("latency", {127'd0, line_valid_o}, 128'd1);
    check_eq("proto_clean", {127'd0, proto_err_o}, 128'd0);
    @(negedge clk_i);
    check_eq("pulse_width", {127'd0, line_valid_o}, 128'd0);
    check_eq("data_hold", line_data_o, {64'hB, 64'hA});
    wait_drain("drain_c");

    // nc single word, upper slot must be zeroed
    push_req(4'd1, 1'b1);
    expect_line({64'h0, 64'h1234}, 4'd1, 1'b1, 1'b0);
    beat(64'h1234, 4'd1, 1'b1, 2'b00);
    wait_drain("drain_nc");

    // two outstanding, third push refused
    push_req(4'd2, 1'b0);
    push_req(4'd3, 1'b0);
    check_eq("full_ready", {127'd0, req_ready_o}, 128'd0);
    push_req(4'd4, 1'b0);
    check_eq("busy_pending", {127'd0, busy_o}, 128'd1);
    expect_line({64'h21, 64'h20}, 4'd2, 1'b0, 1'b0);
    expect_line({64'h31, 64'h30}, 4'd3, 1'b0, 1'b0);
    beat(64'h20, 4'd2, 1'b0, 2'b00);
    beat(64'h21, 4'd2, 1'b1, 2'b00);
    beat(64'h30, 4'd3, 1'b0, 2'b00);
    beat(64'h31, 4'd3, 1'b1, 2'b00);
    check_eq("busy_idle", {127'd0, busy_o}, 128'd0);
    check_eq("ready_idle", {127'd0, req_ready_o}, 128'd1);
    wait_drain("drain_b2b");

    // error-response line then a clean line
    push_req(4'd6, 1'b0);
    beat(64'h60, 4'd6, 1'b0, 2'b10);
    expect_line({64'h61, 64'h60}, 4'd6, 1'b0, ErrEn);
    beat(64'h61, 4'd6, 1'b1, 2'b00);
    push_req(4'd7, 1'b0);
    beat(64'h70, 4'd7, 1'b0, 2'b00);
    expect_line({64'h71, 64'h70}, 4'd7, 1'b0, 1'b0);
    beat(64'h71, 4'd7, 1'b1, 2'b00);
    wait_drain("drain_err");
    check_eq("slverr_not_proto", {127'd0, proto_err_o}, 128'd0);

    // early last: slot 1 keeps the previous line's word
    push_req(4'd8, 1'b0);
    expect_line({64'h71, 64'hC}, 4'd8, 1'b0, 1'b0);
    beat(64'hC, 4'd8, 1'b1, 2'b00);
    check_eq("early_last_proto", {127'd0, proto_err_o}, 128'd1);
    wait_drain("drain_bad");
    check_eq("proto_sticky", {127'd0, proto_err_o}, 128'd1);
    do_reset();
    check_eq("proto_cleared", {127'd0, proto_err_o}, 128'd0);

    // id mismatch
    push_req(4'd4, 1'b0);
    beat(64'hD, 4'd5, 1'b0, 2'b00);
    check_eq("id_proto", {127'd0, proto_err_o}, 128'd1);
    expect_line({64'hE, 64'hD}, 4'd4, 1'b0, 1'b0);
    beat(64'hE, 4'd4, 1'b1, 2'b00);
    wait_drain("drain_id");
    do_reset();

    // reset mid-burst discards everything
    push_req(4'd9, 1'b0);
    beat(64'h90, 4'd9, 1'b0, 2'b00);
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_ready", {127'd0, req_ready_o}, 128'd1);
    check_eq("mid_rst_busy", {127'd0, busy_o}, 128'd0);
    check_eq("mid_rst_beat_ready", {127'd0, beat_ready_o}, 128'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_eq("no_line_after_rst", {127'd0, line_valid_o}, 128'd0);
    end
    @(posedge clk_i);
    #1;
    push_req(4'd10, 1'b0);
    beat(64'hA0, 4'd10, 1'b0, 2'b00);
    expect_line({64'hA1, 64'hA0}, 4'd10, 1'b0, 1'b0);
    beat(64'hA1, 4'd10, 1'b1, 2'b00);
    wait_drain("drain_fresh");
    check_eq("fresh_proto", {127'd0, proto_err_o}, 128'd0);

    // EXOKAY on a fetch is a protocol error only with the error feature
    push_req(4'd12, 1'b1);
    expect_line({64'h0, 64'h55}, 4'd12, 1'b1, 1'b0);
    beat(64'h55, 4'd12, 1'b1, 2'b01);
    wait_drain("drain_exokay");
    check_eq("exokay_proto", {127'd0, proto_err_o}, {127'd0, ErrEn});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
